// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with credit-limited requests, an
// in-order address queue pairing grants with responses, and a small prefetch
// FIFO feeding the IF-ID register through a valid/ready handshake.
// Redirects flush the FIFO and drop in-flight responses via a discard counter.
// Optional macro INSTR_FETCH_BYPASS_EN: zero-latency bypass from memory
// response to fetch outputs when the FIFO is empty.
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_addr_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CntW = (FIFO_DEPTH > 3) ? 3 : 2;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW:0]   DepthW  = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pend_addr_q, pend_addr_d;
    logic            pend_q, pend_d;
    logic            pend_disc_q, pend_disc_d;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] disc_q, disc_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [31:0]     fifo_addr_q  [FIFO_DEPTH];
    logic [31:0]     aq_addr_q    [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q, aq_wptr_q, aq_rptr_q;

    logic            rv_ok, rv_keep, gnt_ok, byp;
    logic            fifo_push, fifo_pop, credit_ok;
    logic [CntW:0]   credit_sum;
    logic [31:0]     aq_head;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_addr_i[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Response qualification, output selection and request generation.
    always_comb begin
        aq_head = aq_addr_q[aq_rptr_q];
        // A response with nothing outstanding is a protocol violation: ignore it.
        rv_ok   = instr_rvalid_i && (out_q != '0);
        rv_keep = rv_ok && !redirect_i && (disc_q == '0);
`ifdef INSTR_FETCH_BYPASS_EN
        byp     = rv_keep && (cnt_q == '0);
`else
        byp     = 1'b0;
`endif
        fetch_valid_o = !redirect_i && ((cnt_q != '0) || byp);
        fetch_instr_o = byp ? instr_rdata_i : fifo_instr_q[rptr_q];
        fetch_addr_o  = byp ? aq_head : fifo_addr_q[rptr_q];
        fifo_pop  = fetch_valid_o && fetch_ready_i && (cnt_q != '0);
        fifo_push = rv_keep && !(byp && fetch_ready_i);
        // Pop-aware credit keeps one instruction per cycle with zero-wait memory.
        credit_sum = {1'b0, out_q} + {1'b0, cnt_q} - {{CntW{1'b0}}, fifo_pop};
        credit_ok  = credit_sum < DepthW;
        // A pending request is never retracted; no fresh request in a redirect cycle.
        instr_req_o  = (state_q == StRun) && (pend_q || (!redirect_i && credit_ok));
        instr_addr_o = pend_q ? pend_addr_q : pc_q;
        gnt_ok       = instr_req_o && instr_gnt_i;
    end

    // Next-state logic for the FSM, pc, pending request and counters.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase

        pend_d      = instr_req_o && !instr_gnt_i;
        pend_addr_d = instr_addr_o;

        // Marks a pending request that was overtaken by a redirect.
        pend_disc_d = redirect_i ? (instr_req_o && !instr_gnt_i) : (pend_disc_q && !gnt_ok);

        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_addr_i[31:2], 2'b00};
        end else if (gnt_ok && !pend_disc_q) begin
            pc_d = instr_addr_o + 32'd4;
        end

        out_d = out_q + CntW'(gnt_ok) - CntW'(rv_ok);

        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            disc_d = out_d;
        end else begin
            disc_d = disc_q - CntW'(rv_ok && (disc_q != '0)) + CntW'(gnt_ok && pend_disc_q);
        end

        cnt_d = redirect_i ? '0 : cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StBoot;
            pc_q        <= {BOOT_ADDR[31:2], 2'b00};
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_disc_q <= 1'b0;
            out_q       <= '0;
            disc_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            pend_disc_q <= pend_disc_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Prefetch FIFO storage and pointers; a redirect empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_addr_q[i]  <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (fifo_push) begin
                fifo_instr_q[wptr_q] <= instr_rdata_i;
                fifo_addr_q[wptr_q]  <= aq_head;
            end
            if (redirect_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (fifo_push) wptr_q <= ptr_inc(wptr_q);
                if (fifo_pop)  rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

    // Address queue: one entry per granted request, retired by its response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                aq_addr_q[i] <= '0;
            end
            aq_wptr_q <= '0;
            aq_rptr_q <= '0;
        end else begin
            if (gnt_ok) begin
                aq_addr_q[aq_wptr_q] <= instr_addr_o;
                aq_wptr_q            <= ptr_inc(aq_wptr_q);
            end
            if (rv_ok) aq_rptr_q <= ptr_inc(aq_rptr_q);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model with configurable
// latency and grant blocking, scoreboard of expected fetch addresses.
module tb_instr_fetch;

    localparam logic [31:0] BOOT = 32'hFFFF_FFF8;
`ifdef INSTR_FETCH_BYPASS_EN
    localparam int FirstValid = 2;
`else
    localparam int FirstValid = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_addr_o;

    instr_fetch #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_ready_i   (fetch_ready_i),
        .fetch_instr_o   (fetch_instr_o),
        .fetch_addr_o    (fetch_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       resp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] sb[$];
    logic [31:0] exp_a;
    int          lat = 1;
    int          mem_cyc = 0;
    bit          gnt_block = 1'b0;
    bit          inject_stray = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Memory model: rvalid decided first, then grant against the settled request.
    always @(negedge clk) begin
        resp_t r;
        #1;
        if (rst_i) begin
            resp_q.delete();
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_gnt_i    = 1'b0;
        end else begin
            mem_cyc++;
            if (inject_stray) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = 32'hDEAD_BEEF;
            end else if (resp_q.size() > 0 && resp_q[0].due <= mem_cyc) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = ~resp_q[0].addr;
                void'(resp_q.pop_front());
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = '0;
            end
            #1;
            instr_gnt_i = instr_req_o && !gnt_block;
            if (instr_req_o && instr_gnt_i) begin
                r.addr = instr_addr_o;
                r.due  = mem_cyc + lat;
                resp_q.push_back(r);
                gnt_log.push_back(instr_addr_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Leaves the bench at the negedge that starts cycle 0 (BOOT).
    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1;
        redirect_i = 1'b0;
        fetch_ready_i = 1'b0;
        inject_stray = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        gnt_log.delete();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1;
        gnt_block = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        fetch_ready_i = 1'b0;
        redirect_i = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        n_checks++; if (instr_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", instr_req_o); else n_pass++;
        n_checks++; if (instr_addr_o !== BOOT) $display("FAIL rst_addr: got %h want %h", instr_addr_o, BOOT); else n_pass++;
        n_checks++; if (fetch_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", fetch_valid_o); else n_pass++;
        n_checks++; if (fetch_instr_o !== 32'h0) $display("FAIL rst_instr: got %h want 0", fetch_instr_o); else n_pass++;
        n_checks++; if (fetch_addr_o !== 32'h0) $display("FAIL rst_faddr: got %h want 0", fetch_addr_o); else n_pass++;
        @(negedge clk);
        rst_i = 1'b0;
        #4;
        n_checks++; if (instr_req_o !== 1'b0) $display("FAIL boot_noreq: got %b want 0", instr_req_o); else n_pass++;
        @(negedge clk);
        #4;
        n_checks++; if (instr_req_o !== 1'b1) $display("FAIL first_req: got %b want 1", instr_req_o); else n_pass++;
        n_checks++; if (instr_addr_o !== BOOT) $display("FAIL first_addr: got %h want %h", instr_addr_o, BOOT); else n_pass++;
    endtask

    task automatic test_sequential();
        int first = -1;
        int last = -1;
        lat = 1;
        gnt_block = 1'b0;
        apply_reset();
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(BOOT + 32'(4 * i));
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                if (first < 0) first = c;
                last = c;
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL seq_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
                n_checks++; if (fetch_instr_o !== ~exp_a) $display("FAIL seq_instr: got %h want %h", fetch_instr_o, ~exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL seq_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
        n_checks++; if (first != FirstValid) $display("FAIL seq_latency: first valid cycle %0d want %0d", first, FirstValid); else n_pass++;
        n_checks++; if (last - first != 9) $display("FAIL seq_throughput: 10 words took %0d cycles want 10", last - first + 1); else n_pass++;
        n_checks++; if (gnt_log.size() < 3 || gnt_log[2] !== 32'h0) $display("FAIL seq_wrap_req: third grant not 00000000 (grants %0d)", gnt_log.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        int seen = 0;
        lat = 1;
        gnt_block = 1'b0;
        apply_reset();
        fetch_ready_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #4;
            if (fetch_valid_o) begin
                seen++;
                if (fetch_addr_o !== BOOT || fetch_instr_o !== ~BOOT) stable = 1'b0;
            end
        end
        n_checks++; if (gnt_log.size() != 2) $display("FAIL bp_grants: got %0d want 2", gnt_log.size()); else n_pass++;
        n_checks++; if (seen != 12 - FirstValid) $display("FAIL bp_valid_cycles: got %0d want %0d", seen, 12 - FirstValid); else n_pass++;
        n_checks++; if (!stable) $display("FAIL bp_stable: output changed while stalled, want %h held", BOOT); else n_pass++;
        n_checks++; if (instr_req_o !== 1'b0) $display("FAIL bp_full_noreq: got %b want 0", instr_req_o); else n_pass++;
        for (int i = 0; i < 4; i++) sb.push_back(BOOT + 32'(4 * i));
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            fetch_ready_i = 1'b1;
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL bp_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL bp_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_redirect_discard();
        lat = 3;
        gnt_block = 1'b0;
        apply_reset();
        fetch_ready_i = 1'b1;
        for (int c = 0; c < 10 && gnt_log.size() < 2; c++) @(negedge clk);
        n_checks++; if (gnt_log.size() != 2) $display("FAIL rd_setup: grants %0d want 2", gnt_log.size()); else n_pass++;
        redirect_i = 1'b1;
        redirect_addr_i = 32'h0000_0103;
        #4;
        n_checks++; if (fetch_valid_o !== 1'b0) $display("FAIL rd_gate: got %b want 0", fetch_valid_o); else n_pass++;
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(4 * i));
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL rd_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
                n_checks++; if (fetch_instr_o !== ~exp_a) $display("FAIL rd_instr: got %h want %h", fetch_instr_o, ~exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL rd_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
        n_checks++; if (gnt_log.size() < 3 || gnt_log[2] !== 32'h100) $display("FAIL rd_target_req: third grant not 00000100"); else n_pass++;
    endtask

    task automatic test_redirect_pending();
        bit stable = 1'b1;
        lat = 1;
        gnt_block = 1'b1;
        apply_reset();
        fetch_ready_i = 1'b1;
        @(negedge clk);
        #4;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT) $display("FAIL rp_pending: req %b addr %h want 1 %h", instr_req_o, instr_addr_o, BOOT); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            redirect_i = (c == 0);
            redirect_addr_i = 32'h0000_0200;
            #4;
            if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT) stable = 1'b0;
        end
        n_checks++; if (!stable) $display("FAIL rp_hold: request changed during grant hold, want %h", BOOT); else n_pass++;
        for (int i = 0; i < 3; i++) sb.push_back(32'h200 + 32'(4 * i));
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            gnt_block = 1'b0;
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL rp_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL rp_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
        n_checks++; if (gnt_log.size() < 2 || gnt_log[0] !== BOOT || gnt_log[1] !== 32'h200) $display("FAIL rp_grant_order: grants %0d, want %h then 00000200", gnt_log.size(), BOOT); else n_pass++;
    endtask

    task automatic test_redirect_rvalid();
        lat = 1;
        gnt_block = 1'b0;
        apply_reset();
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(BOOT + 32'(4 * i));
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL rv_pre_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
            end
        end
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_addr_i = 32'h0000_0300;
        #4;
        n_checks++; if (instr_rvalid_i !== 1'b1) $display("FAIL rv_setup: rvalid %b want 1", instr_rvalid_i); else n_pass++;
        n_checks++; if (fetch_valid_o !== 1'b0) $display("FAIL rv_gate: got %b want 0", fetch_valid_o); else n_pass++;
        sb.delete();
        for (int i = 0; i < 3; i++) sb.push_back(32'h300 + 32'(4 * i));
        @(negedge clk);
        redirect_i = 1'b0;
        #4;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) $display("FAIL rv_next_req: req %b addr %h want 1 00000300", instr_req_o, instr_addr_o); else n_pass++;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            if (c > 0) #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL rv_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL rv_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_stray_rvalid();
        lat = 1;
        gnt_block = 1'b1;
        apply_reset();
        fetch_ready_i = 1'b1;
        @(negedge clk);
        inject_stray = 1'b1;
        #4;
        n_checks++; if (fetch_valid_o !== 1'b0) $display("FAIL stray_valid0: got %b want 0", fetch_valid_o); else n_pass++;
        @(negedge clk);
        inject_stray = 1'b0;
        gnt_block = 1'b0;
        #4;
        n_checks++; if (fetch_valid_o !== 1'b0) $display("FAIL stray_valid1: got %b want 0", fetch_valid_o); else n_pass++;
        for (int i = 0; i < 4; i++) sb.push_back(BOOT + 32'(4 * i));
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            @(negedge clk);
            #4;
            if (fetch_valid_o && fetch_ready_i) begin
                exp_a = sb.pop_front();
                n_checks++; if (fetch_addr_o !== exp_a) $display("FAIL stray_addr: got %h want %h", fetch_addr_o, exp_a); else n_pass++;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL stray_timeout: %0d words missing, want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_discard();
        test_redirect_pending();
        test_redirect_rvalid();
        test_stray_rvalid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
